// File: rtl/controle_pkg.sv
// controle_pkg: state encoding and datapath select/operation constants shared by controle and the datapath
package controle_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_X, MUL_AX, MUL_AXX, MUL_BX, ADD_SH, ADD_C, DONE} state_t;
    localparam logic [1:0] SEL_ZERO = 2'b00;
    localparam logic [1:0] SEL_A    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_C    = 2'b11;
    localparam logic [1:0] M1_CONST = 2'b00;
    localparam logic [1:0] M1_X     = 2'b01;
    localparam logic [1:0] M1_S     = 2'b10;
    localparam logic [1:0] M1_H     = 2'b11;
    localparam logic [1:0] M2_X     = 2'b00;
    localparam logic [1:0] M2_CONST = 2'b01;
    localparam logic [1:0] M2_S     = 2'b10;
    localparam logic [1:0] M2_H     = 2'b11;
    localparam logic       H_ADD    = 1'b0;
    localparam logic       H_MUL    = 1'b1;
endpackage

// File: rtl/controle.sv
// controle: Moore FSM sequencing the datapath through A*X*X + B*X + C, with a completed-operation counter
module controle
    import controle_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               lx,
    output logic [1:0]         m0,
    output logic [1:0]         m1,
    output logic [1:0]         m2,
    output logic               h,
    output logic               ls,
    output logic               lh,
    output logic               done,
    output logic [COUNT_W-1:0] op_count
);
    state_t state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        busy    = (state_q != IDLE);
        lx      = 1'b0;
        m0      = SEL_ZERO;
        m1      = M1_CONST;
        m2      = M2_X;
        h       = H_ADD;
        ls      = 1'b0;
        lh      = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE:    state_d = start ? LOAD_X : IDLE;
            LOAD_X: begin
                lx      = 1'b1;
                state_d = MUL_AX;
            end
            MUL_AX: begin
                m1      = M1_CONST;
                m0      = SEL_A;
                m2      = M2_X;
                h       = H_MUL;
                lh      = 1'b1;
                state_d = MUL_AXX;
            end
            MUL_AXX: begin
                m1      = M1_H;
                m2      = M2_X;
                h       = H_MUL;
                lh      = 1'b1;
                state_d = MUL_BX;
            end
            MUL_BX: begin
                m1      = M1_CONST;
                m0      = SEL_B;
                m2      = M2_X;
                h       = H_MUL;
                ls      = 1'b1;
                state_d = ADD_SH;
            end
            ADD_SH: begin
                m1      = M1_S;
                m2      = M2_H;
                h       = H_ADD;
                ls      = 1'b1;
                state_d = ADD_C;
            end
            ADD_C: begin
                m1      = M1_S;
                m2      = M2_CONST;
                m0      = SEL_C;
                h       = H_ADD;
                ls      = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                count_d = count_q + 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign op_count = count_q;
endmodule

// File: tb/tb_controle.sv
// tb_controle: checks controle against a per-cycle phase model and a behavioural polynomial datapath
module tb_controle;
    logic ck = 1'b0;
    logic rst, start;
    logic [15:0] xa, aa, ba, ca;
    logic busy, lx, h, ls, lh, done;
    logic [1:0] m0, m1, m2;
    logic [7:0] op_count;
    logic busy2, lx2, h2, ls2, lh2, done2;
    logic [1:0] m02, m12, m22;
    logic [1:0] op_count2;

    controle #(.COUNT_W(8)) dut (
        .ck(ck), .rst(rst), .start(start), .busy(busy), .lx(lx), .m0(m0), .m1(m1), .m2(m2),
        .h(h), .ls(ls), .lh(lh), .done(done), .op_count(op_count)
    );
    controle #(.COUNT_W(2)) dut2 (
        .ck(ck), .rst(rst), .start(start), .busy(busy2), .lx(lx2), .m0(m02), .m1(m12), .m2(m22),
        .h(h2), .ls(ls2), .lh(lh2), .done(done2), .op_count(op_count2)
    );

    always #5 ck = ~ck;

    // datapath driven by the DUT's controls; Resultado is sr
    logic [15:0] xr, hr, sr, kv, op1, op2, alu;
    always_comb begin
        kv  = (m0 == 2'd0) ? 16'd0 : (m0 == 2'd1) ? aa : (m0 == 2'd2) ? ba : ca;
        op1 = (m1 == 2'd0) ? kv : (m1 == 2'd1) ? xr : (m1 == 2'd2) ? sr : hr;
        op2 = (m2 == 2'd0) ? xr : (m2 == 2'd1) ? kv : (m2 == 2'd2) ? sr : hr;
        alu = h ? op1 * op2 : op1 + op2;
    end
    always @(posedge ck) begin
        if (lx) xr <= xa;
        if (ls) sr <= alu;
        if (lh) hr <= alu;
    end

    typedef struct {
        logic        start;
        logic [11:0] exp;
    } vec_t;

    // phase 0 = idle, 1..7 = cycles after start; fields {busy,lx,m0,m1,m2,h,ls,lh,done}
    logic [11:0] pout [8];
    vec_t nom [10];
    int phase, cnt, errors, checks;
    logic [15:0] exp_res;
    int wrap_exp [5] = '{1, 2, 3, 0, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        if (phase == 0) begin
            if (start) begin
                phase   = 1;
                exp_res = aa * xa * xa + ba * xa + ca;
            end
        end else if (phase == 7) begin
            phase = 0;
            cnt++;
        end else phase++;
        @(negedge ck);
    endtask

    task automatic check_all();
        chk("outs", {20'd0, busy, lx, m0, m1, m2, h, ls, lh, done}, {20'd0, pout[phase]});
        chk("outs_w2", {20'd0, busy2, lx2, m02, m12, m22, h2, ls2, lh2, done2}, {20'd0, pout[phase]});
        chk("op_count", {24'd0, op_count}, cnt % 256);
        chk("op_count_w2", {30'd0, op_count2}, cnt % 4);
        if (phase == 7) chk("resultado", {16'd0, sr}, {16'd0, exp_res});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_outs", {20'd0, busy, lx, m0, m1, m2, h, ls, lh, done}, 32'd0);
        chk("rst_count", {24'd0, op_count, op_count2}, 32'd0);
        #1 rst = 1'b0;
        phase = 0;
        cnt   = 0;
    endtask

    task automatic run_one(input logic [15:0] x, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] res);
        xa = x; aa = a; ba = b; ca = c;
        start = 1'b1;
        tick();
        check_all();
        start = 1'b0;
        repeat (6) begin
            tick();
            check_all();
        end
        chk("run_done", {31'd0, done}, 32'd1);
        chk("run_res", {16'd0, sr}, {16'd0, res});
        tick();
        check_all();
    endtask

    initial begin
        pout[0] = 12'b0_0_00_00_00_0_0_0_0;
        pout[1] = 12'b1_1_00_00_00_0_0_0_0;
        pout[2] = 12'b1_0_01_00_00_1_0_1_0;
        pout[3] = 12'b1_0_00_11_00_1_0_1_0;
        pout[4] = 12'b1_0_10_00_00_1_1_0_0;
        pout[5] = 12'b1_0_00_10_11_0_1_0_0;
        pout[6] = 12'b1_0_11_10_01_0_1_0_0;
        pout[7] = 12'b1_0_00_00_00_0_0_0_1;
        for (int i = 0; i < 10; i++) begin
            nom[i].start = (i == 0);
            nom[i].exp   = (i < 7) ? pout[i + 1] : 12'd0;
        end
        errors = 0; checks = 0; phase = 0; cnt = 0;
        rst = 1'b1; start = 1'b0;
        xa = '0; aa = '0; ba = '0; ca = '0;
        repeat (2) @(negedge ck);
        do_reset();

        repeat (10) begin
            tick();
            check_all();
        end

        xa = 16'd3; aa = 16'd2; ba = 16'd5; ca = 16'd7;
        for (int i = 0; i < 10; i++) begin
            start = nom[i].start;
            tick();
            chk($sformatf("nom_c%0d", i + 1), {20'd0, busy, lx, m0, m1, m2, h, ls, lh, done}, {20'd0, nom[i].exp});
            if (i == 6) chk("nom_res", {16'd0, sr}, 32'd40);
            check_all();
        end
        chk("nom_count", {24'd0, op_count}, 32'd1);

        run_one(16'd256, 16'd1, 16'd0, 16'd0, 16'd0);
        run_one(16'hFFFF, 16'd0, 16'd1, 16'd1, 16'd0);

        begin
            int base;
            base  = cnt;
            start = 1'b1;
            for (int cyc = 1; cyc <= 16; cyc++) begin
                tick();
                check_all();
                chk($sformatf("b2b_done_c%0d", cyc), {31'd0, done}, {31'd0, (cyc == 7 || cyc == 15)});
                if (cyc <= 15) chk($sformatf("b2b_busy_c%0d", cyc), {31'd0, busy}, {31'd0, cyc != 8});
            end
            chk("b2b_count", {24'd0, op_count}, (base + 2) % 256);
            start = 1'b0;
            repeat (8) begin
                tick();
                check_all();
            end
        end

        do_reset();
        xa = 16'd9; aa = 16'd4; ba = 16'd1; ca = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("abort_in_mulbx", {20'd0, busy, lx, m0, m1, m2, h, ls, lh, done}, {20'd0, pout[4]});
        #2 rst = 1'b1;
        #1;
        chk("abort_outs", {20'd0, busy, lx, m0, m1, m2, h, ls, lh, done}, 32'd0);
        chk("abort_count", {24'd0, op_count}, 32'd0);
        #1 rst = 1'b0;
        phase = 0;
        cnt   = 0;
        repeat (10) begin
            tick();
            check_all();
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        run_one(16'd3, 16'd2, 16'd5, 16'd7, 16'd40);
        chk("abort_after", {24'd0, op_count}, 32'd1);

        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_one(16'(k + 1), 16'd1, 16'd1, 16'd1, 16'((k + 1) * (k + 1) + (k + 1) + 1));
            chk($sformatf("wrap_w2_%0d", k), {30'd0, op_count2}, wrap_exp[k]);
        end

        do_reset();
        repeat (400) begin
            if (phase == 0 || phase == 7) begin
                xa = 16'($urandom); aa = 16'($urandom);
                ba = 16'($urandom); ca = 16'($urandom);
            end
            start = 1'($urandom_range(0, 1));
            tick();
            check_all();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
